// File: rtl/sha3_absorb_ctrl.sv
// Absorb-phase sequencer for a SHA3 Keccak core: splits a 32-bit AXI-Stream message into
// rate-sized blocks, inserts 0x06..0x80 padding and issues word writes, permutations and squeeze.
module sha3_absorb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BLK_CNT_W  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic [1:0]              s_tuser,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic                    c_init,
  output logic                    c_wvalid,
  output logic [5:0]              c_widx,
  output logic [DATA_WIDTH-1:0]   c_wdata,
  output logic                    c_perm_start,
  input  logic                    c_perm_done,
  output logic                    c_squeeze,
  output logic                    msg_done,
  output logic [BLK_CNT_W-1:0]    msg_blocks,
  output logic [2:0]              dbg_state
);

  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PAD, S_FINAL, S_PERM_START, S_PERM_WAIT, S_SQUEEZE
  } state_t;

  state_t                  state_q, state_d;
  logic [5:0]              rate_q, rate_d;
  logic [5:0]              widx_q, widx_d;
  logic                    final_q, final_d;
  logic                    pad_pend_q, pad_pend_d;
  logic                    tready_q, tready_d;
  logic                    init_q, init_d;
  logic                    wvalid_q, wvalid_d;
  logic [5:0]              cwidx_q, cwidx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    pstart_q, pstart_d;
  logic                    squeeze_q, squeeze_d;
  logic [BLK_CNT_W-1:0]    blocks_q, blocks_d;

  logic                    at_end;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   keep_mask;
  logic [4:0]              pad_shift;
  logic [DATA_WIDTH-1:0]   tail_word;

  function automatic logic [5:0] rate_of(input logic [1:0] v);
    case (v)
      2'd0:    rate_of = 6'd36;
      2'd1:    rate_of = 6'd34;
      2'd2:    rate_of = 6'd26;
      default: rate_of = 6'd18;
    endcase
  endfunction

  // s_tready is registered and high exactly while the FSM sits in ABSORB.
  assign accept = s_tvalid && tready_q;
  assign at_end = (widx_q == rate_q - 6'd1);

  // Last partial beat: keep the valid bytes, put 0x06 at byte k, and 0x80 on top if the block ends here.
  always_comb begin
    keep_mask = '0;
    for (int b = 0; b < KW; b++) keep_mask[8*b +: 8] = {8{s_tkeep[b]}};
    case (s_tkeep)
      4'h1:    pad_shift = 5'd8;
      4'h3:    pad_shift = 5'd16;
      4'h7:    pad_shift = 5'd24;
      default: pad_shift = 5'd0;
    endcase
    tail_word = (s_tdata & keep_mask) | (DATA_WIDTH'(8'h06) << pad_shift);
    if (at_end) tail_word[DATA_WIDTH-1] = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= S_IDLE;
      rate_q     <= '0;
      widx_q     <= '0;
      final_q    <= 1'b0;
      pad_pend_q <= 1'b0;
      tready_q   <= 1'b0;
      init_q     <= 1'b0;
      wvalid_q   <= 1'b0;
      cwidx_q    <= '0;
      wdata_q    <= '0;
      pstart_q   <= 1'b0;
      squeeze_q  <= 1'b0;
      blocks_q   <= '0;
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      widx_q     <= widx_d;
      final_q    <= final_d;
      pad_pend_q <= pad_pend_d;
      tready_q   <= tready_d;
      init_q     <= init_d;
      wvalid_q   <= wvalid_d;
      cwidx_q    <= cwidx_d;
      wdata_q    <= wdata_d;
      pstart_q   <= pstart_d;
      squeeze_q  <= squeeze_d;
      blocks_q   <= blocks_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (s_tvalid) state_d = S_ABSORB;
      S_ABSORB: begin
        if (accept) begin
          if (at_end)                              state_d = S_PERM_START;
          else if (s_tlast && s_tkeep == {KW{1'b1}}) state_d = S_PAD;
          else if (s_tlast)                        state_d = S_FINAL;
        end
      end
      S_PAD:        state_d = at_end ? S_PERM_START : S_FINAL;
      S_FINAL:      state_d = S_PERM_START;
      S_PERM_START: state_d = S_PERM_WAIT;
      S_PERM_WAIT: begin
        if (c_perm_done) begin
          if (final_q)         state_d = S_SQUEEZE;
          else if (pad_pend_q) state_d = S_PAD;
          else                 state_d = S_ABSORB;
        end
      end
      S_SQUEEZE:    state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rate_d     = rate_q;
    widx_d     = widx_q;
    final_d    = final_q;
    pad_pend_d = pad_pend_q;
    tready_d   = (state_d == S_ABSORB);
    init_d     = 1'b0;
    wvalid_d   = 1'b0;
    cwidx_d    = '0;
    wdata_d    = '0;
    pstart_d   = 1'b0;
    squeeze_d  = 1'b0;
    blocks_d   = blocks_q;
    case (state_q)
      S_IDLE: begin
        if (s_tvalid) begin
          rate_d     = rate_of(s_tuser);
          init_d     = 1'b1;
          widx_d     = '0;
          blocks_d   = '0;
          final_d    = 1'b0;
          pad_pend_d = 1'b0;
        end
      end
      S_ABSORB: begin
        if (accept) begin
          wvalid_d = 1'b1;
          cwidx_d  = widx_q;
          if (!s_tlast || s_tkeep == {KW{1'b1}}) begin
            wdata_d = s_tdata;
            if (s_tlast && at_end) pad_pend_d = 1'b1;
          end else begin
            wdata_d = tail_word;
            if (at_end) final_d = 1'b1;
          end
          if (!at_end) widx_d = widx_q + 6'd1;
        end
      end
      S_PAD: begin
        wvalid_d = 1'b1;
        cwidx_d  = widx_q;
        wdata_d  = at_end ? 32'h8000_0006 : 32'h0000_0006;
        if (at_end) final_d = 1'b1;
      end
      S_FINAL: begin
        wvalid_d = 1'b1;
        cwidx_d  = rate_q - 6'd1;
        wdata_d  = 32'h8000_0000;
        final_d  = 1'b1;
      end
      S_PERM_START: begin
        pstart_d = 1'b1;
        if (!(&blocks_q)) blocks_d = blocks_q + BLK_CNT_W'(1);
      end
      S_PERM_WAIT: begin
        if (c_perm_done) begin
          widx_d = '0;
          if (!final_q && pad_pend_q) pad_pend_d = 1'b0;
        end
      end
      S_SQUEEZE: squeeze_d = 1'b1;
      default: ;
    endcase
  end

  assign s_tready     = tready_q;
  assign c_init       = init_q;
  assign c_wvalid     = wvalid_q;
  assign c_widx       = cwidx_q;
  assign c_wdata      = wdata_q;
  assign c_perm_start = pstart_q;
  assign c_squeeze    = squeeze_q;
  assign msg_done     = squeeze_q;
  assign msg_blocks   = blocks_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Bench for sha3_absorb_ctrl: a padding model queues the expected core writes, a negedge
// monitor pops them and emulates the core's permutation-done response.
module tb_sha3_absorb_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic [1:0]  s_tuser = '0;
  logic        s_tvalid = 1'b0;
  logic        c_perm_done = 1'b0;
  logic        s_tready, c_init, c_wvalid, c_perm_start, c_squeeze, msg_done;
  logic [5:0]  c_widx;
  logic [31:0] c_wdata;
  logic [15:0] msg_blocks;
  logic [2:0]  dbg_state;

  sha3_absorb_ctrl #(.DATA_WIDTH(32), .BLK_CNT_W(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .c_init(c_init), .c_wvalid(c_wvalid), .c_widx(c_widx), .c_wdata(c_wdata),
    .c_perm_start(c_perm_start), .c_perm_done(c_perm_done),
    .c_squeeze(c_squeeze), .msg_done(msg_done), .msg_blocks(msg_blocks),
    .dbg_state(dbg_state)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;
  logic [37:0] exp_q[$];
  logic [37:0] exp_w;
  logic [7:0]  msg[0:511];
  logic [7:0]  pb[0:1023];
  int init_cnt = 0, perm_cnt = 0, sq_cnt = 0;
  int perm_delay = 1;
  int done_cnt = -1;
  bit in_wait = 1'b0;

  // Monitor and core emulation: scoreboard writes, count pulses, answer permutations after perm_delay.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      done_cnt = -1;
      in_wait = 1'b0;
      c_perm_done = 1'b0;
    end else begin
      if (c_wvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected: got idx=%0d data=%h, required no write", c_widx, c_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({c_widx, c_wdata} !== exp_w) begin
            failures++;
            $display("FAIL write: got idx=%0d data=%h, required idx=%0d data=%h",
                     c_widx, c_wdata, exp_w[37:32], exp_w[31:0]);
          end
        end
      end
      if (c_init) init_cnt++;
      if (c_perm_start) perm_cnt++;
      if (c_squeeze) sq_cnt++;
      if (c_squeeze || msg_done) begin
        checks++;
        if (c_squeeze !== msg_done) begin
          failures++;
          $display("FAIL squeeze_done_align: got squeeze=%b msg_done=%b, required equal", c_squeeze, msg_done);
        end
      end
      if (in_wait) begin
        checks++;
        if (s_tready !== 1'b0) begin
          failures++;
          $display("FAIL tready_in_perm_wait: got %b, required 0", s_tready);
        end
      end
      c_perm_done = 1'b0;
      if (done_cnt == 0) begin
        c_perm_done = 1'b1;
        done_cnt = -1;
        in_wait = 1'b0;
      end else if (done_cnt > 0) begin
        done_cnt--;
      end
      if (c_perm_start) begin
        done_cnt = perm_delay - 1;
        in_wait = 1'b1;
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] u);
    bit acc = 1'b0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    for (int c = 0; c < 3000 && !acc; c++) begin
      acc = s_tready;
      @(posedge ACLK);
      @(negedge ACLK);
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL beat_timeout: got no s_tready within 3000 cycles, required acceptance");
    end
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge ACLK);
  endtask

  task automatic fill_rand(input int L);
    for (int i = 0; i < L; i++) msg[i] = 8'($urandom_range(0, 255));
  endtask

  // Pad msg[0..L) per SHA3 into whole rate blocks, queue the words the core must receive, drive beats.
  task automatic drive_msg(input int v, input int L, input bit empty_tail, output int blocks);
    int r, rb, P, lw, nfull, rem, s0;
    logic [31:0] d;
    r = (v == 0) ? 36 : (v == 1) ? 34 : (v == 2) ? 26 : 18;
    rb = 4 * r;
    P = ((L + 1 + rb - 1) / rb) * rb;
    for (int i = 0; i < P; i++) pb[i] = (i < L) ? msg[i] : 8'h00;
    pb[L] = pb[L] | 8'h06;
    pb[P-1] = pb[P-1] | 8'h80;
    lw = L / 4;
    for (int w = 0; w < P / 4; w++)
      if (w <= lw || w == P / 4 - 1)
        exp_q.push_back({6'(w % r), pb[4*w+3], pb[4*w+2], pb[4*w+1], pb[4*w]});
    blocks = P / rb;
    s0 = sq_cnt;
    nfull = L / 4;
    rem = L % 4;
    for (int i = 0; i < nfull; i++)
      send_beat({msg[4*i+3], msg[4*i+2], msg[4*i+1], msg[4*i]}, 4'hF,
                (i == nfull - 1) && rem == 0 && !empty_tail,
                (i == 0) ? 2'(v) : 2'($urandom_range(0, 3)));
    if (rem != 0) begin
      d = '0;
      for (int b = 0; b < rem; b++) d[8*b +: 8] = msg[4*nfull+b];
      send_beat(d, 4'((1 << rem) - 1), 1'b1, (nfull == 0) ? 2'(v) : 2'($urandom_range(0, 3)));
    end else if (L == 0 || empty_tail) begin
      send_beat(32'h0, 4'h0, 1'b1, (nfull == 0) ? 2'(v) : 2'($urandom_range(0, 3)));
    end
    for (int c = 0; c < 5000 && sq_cnt == s0; c++) @(negedge ACLK);
    if (sq_cnt == s0) begin
      checks++; failures++;
      $display("FAIL squeeze_timeout: got no c_squeeze within 5000 cycles, required one");
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({s_tready, c_init, c_wvalid, c_perm_start, c_squeeze, msg_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_pulses: got %b, required 000000",
               {s_tready, c_init, c_wvalid, c_perm_start, c_squeeze, msg_done});
    end
    checks++;
    if ({c_widx, c_wdata, msg_blocks} !== 54'b0) begin
      failures++;
      $display("FAIL reset_buses: got widx=%0d wdata=%h blocks=%0d, required 0", c_widx, c_wdata, msg_blocks);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic test_empty_256;
    int blk, i0, p0;
    i0 = init_cnt; p0 = perm_cnt; perm_delay = 1;
    drive_msg(1, 0, 1'b0, blk);
    checks++;
    if (msg_blocks !== 16'd1) begin
      failures++; $display("FAIL empty_blocks: got %0d, required 1", msg_blocks);
    end
    checks++;
    if (init_cnt - i0 != 1 || perm_cnt - p0 != 1) begin
      failures++; $display("FAIL empty_pulses: got init=%0d perm=%0d, required 1 1", init_cnt - i0, perm_cnt - p0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL empty_writes: got %0d missing writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_abc_256;
    int blk;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    drive_msg(1, 3, 1'b0, blk);
    checks++;
    if (msg_blocks !== 16'd1 || exp_q.size() != 0) begin
      failures++; $display("FAIL abc: got blocks=%0d missing=%0d, required 1 0", msg_blocks, exp_q.size());
    end
  endtask

  task automatic test_rate_boundary_512;
    int blk, p0;
    fill_rand(72);
    p0 = perm_cnt;
    drive_msg(3, 72, 1'b0, blk);
    checks++;
    if (msg_blocks !== 16'd2 || perm_cnt - p0 != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL sha512_72: got blocks=%0d perm=%0d missing=%0d, required 2 2 0", msg_blocks, perm_cnt - p0, exp_q.size());
    end
    fill_rand(68);
    msg[68] = 8'hAA; msg[69] = 8'hBB; msg[70] = 8'hCC;
    p0 = perm_cnt;
    drive_msg(3, 71, 1'b0, blk);
    checks++;
    if (msg_blocks !== 16'd1 || perm_cnt - p0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL sha512_71: got blocks=%0d perm=%0d missing=%0d, required 1 1 0", msg_blocks, perm_cnt - p0, exp_q.size());
    end
  endtask

  task automatic test_backpressure_384;
    int blk;
    fill_rand(120);
    perm_delay = 24;
    drive_msg(2, 120, 1'b0, blk);
    perm_delay = 1;
    checks++;
    if (msg_blocks !== 16'(blk) || exp_q.size() != 0) begin
      failures++;
      $display("FAIL sha384_stall: got blocks=%0d missing=%0d, required %0d 0", msg_blocks, exp_q.size(), blk);
    end
  endtask

  task automatic test_random_msgs;
    int blk, v, L;
    for (int n = 0; n < 8; n++) begin
      v = n % 4;
      L = $urandom_range(0, 300);
      fill_rand(L);
      perm_delay = $urandom_range(1, 6);
      drive_msg(v, L, (L % 4 == 0) && (n >= 4), blk);
      checks++;
      if (msg_blocks !== 16'(blk) || exp_q.size() != 0) begin
        failures++;
        $display("FAIL random_msg v=%0d L=%0d: got blocks=%0d missing=%0d, required %0d 0",
                 v, L, msg_blocks, exp_q.size(), blk);
      end
    end
    perm_delay = 1;
  endtask

  task automatic test_reset_abort;
    int blk, i0;
    fill_rand(104);
    perm_delay = 60;
    for (int w = 0; w < 26; w++)
      exp_q.push_back({6'(w), msg[4*w+3], msg[4*w+2], msg[4*w+1], msg[4*w]});
    for (int w = 0; w < 26; w++)
      send_beat({msg[4*w+3], msg[4*w+2], msg[4*w+1], msg[4*w]}, 4'hF, 1'b0, 2'd2);
    for (int c = 0; c < 100 && !in_wait; c++) @(negedge ACLK);
    checks++;
    if (!in_wait || exp_q.size() != 0) begin
      failures++; $display("FAIL abort_setup: got in_wait=%b missing=%0d, required 1 0", in_wait, exp_q.size());
    end
    exp_q.delete();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if ({s_tready, c_init, c_wvalid, c_perm_start, c_squeeze, msg_done, c_widx, c_wdata, msg_blocks} !== '0) begin
      failures++;
      $display("FAIL abort_reset_outputs: got tready=%b wvalid=%b blocks=%0d, required all 0", s_tready, c_wvalid, msg_blocks);
    end
    ARESETn = 1'b1;
    perm_delay = 1;
    @(negedge ACLK);
    i0 = init_cnt;
    fill_rand(144);
    drive_msg(0, 144, 1'b0, blk);
    checks++;
    if (init_cnt - i0 != 1 || msg_blocks !== 16'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_then_224: got init=%0d blocks=%0d missing=%0d, required 1 2 0",
               init_cnt - i0, msg_blocks, exp_q.size());
    end
  endtask

  initial begin
    @(negedge ACLK);
    test_reset();
    test_empty_256();
    test_abc_256();
    test_rate_boundary_512();
    test_backpressure_384();
    test_random_msgs();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
